alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Request-side counterpart of the datapath ALU. Accepts decoded RV32I instruction fields
//  plus operands over a valid/ready request, and decodes opcode/funct3/funct7[5] into the
//  ALU's 4-bit alu_control encoding. Drives the ALU inputs, captures its result and returns
//  result, zero and illegal flags over a valid/ready response.
//  Sits between the multicycle control unit and the combinational ALU.
// PARAMETERS
//  REG_WIDTH  32  operand/result width; equals the ALU and register-file width
// PORTS
//  clk           in   1          clock; all state updates on rising edge
//  reset_b       in   1          synchronous reset, active-low
//  req_valid     in   1          request valid
//  req_ready     out  1          request ready; high only in IDLE
//  opcode        in   7          instruction[6:0]
//  funct3        in   3          instruction[14:12]
//  funct7_5      in   1          instruction[30]
//  rs1_data      in   REG_WIDTH  operand 1
//  rs2_data      in   REG_WIDTH  operand 2 (R-type, branch)
//  imm           in   REG_WIDTH  sign-extended immediate (I-type, load, store)
//  alu_in1       out  REG_WIDTH  to ALU in1, registered
//  alu_in2       out  REG_WIDTH  to ALU in2, registered
//  alu_control   out  4          to ALU alu_control, registered
//  alu_result    in   REG_WIDTH  from ALU result (combinational)
//  resp_valid    out  1          response valid
//  resp_ready    in   1          response ready
//  resp_result   out  REG_WIDTH  captured result; 0 when illegal
//  resp_zero     out  1          resp_result == 0
//  resp_illegal  out  1          request not decodable
// BEHAVIOUR
//  ALU codes: AND=0000 OR=0001 ADD=0010 XOR=0011 SUB=0110.
//  Decode:
//   - R 0110011: funct3 000 -> SUB if funct7_5 else ADD; 100 -> XOR; 110 -> OR; 111 -> AND;
//     in2 = rs2_data.
//   - I 0010011: funct3 000 -> ADD (funct7_5 ignored); 100/110/111 as R-type; in2 = imm.
//   - Load 0000011 / store 0100011: ADD, in2 = imm, funct3 ignored.
//   - Branch 1100011: funct3 000/001 -> SUB, in2 = rs2_data.
//   - All other opcode/funct3 combinations: illegal; alu_control = ADD, in1 = in2 = 0.
//   - in1 = rs1_data always, except when illegal.
//  FSM states: IDLE -> EXEC -> RESP -> IDLE.
//   - IDLE: req_ready=1; on req_valid, register the decoded control and operands; go to EXEC.
//   - EXEC: one cycle. At the clock edge, capture alu_result into resp_result (0 if illegal)
//     and capture resp_zero. Go to RESP.
//   - RESP: resp_valid=1. resp_result, resp_zero and resp_illegal stay stable until
//     resp_valid & resp_ready. On that handshake go to IDLE and drop resp_valid.
//  Latency: request accepted at edge T -> resp_valid high in cycle T+2. Throughput is at most
//   one request per 3 cycles. If resp_ready is already high in RESP, the handshake completes
//   in the first RESP cycle.
//  req_ready is low in EXEC and RESP. A req_valid asserted in those states is not consumed
//   and must be held by the requester.
//  In IDLE, req_ready and resp_valid are never high together. There is no request/response
//   overlap.
//  alu_in*, alu_control hold their last values outside IDLE accept edges.
//  Reset (reset_b low at a rising edge, from any state, including mid-EXEC or RESP):
//   - state=IDLE; any in-flight request is discarded with no response.
//   - req_ready=1 after reset; resp_valid=0; resp_result=0; resp_zero=0; resp_illegal=0.
//   - alu_in1=0; alu_in2=0; alu_control=4'b0010.
//  Arithmetic wraps modulo 2^REG_WIDTH (the ALU does it); no overflow flag.
// TESTING
//  1. R ADD: opcode 0110011, f3 000, f7_5 0, rs1 5, rs2 7 -> alu_control 0010,
//     resp_result 12 at T+2, zero 0.
//  2. R SUB: f7_5 1, rs1 10, rs2 3 -> alu_control 0110, result 7;
//     rs1 0, rs2 1 -> result 32'hFFFF_FFFF.
//  3. Branch BEQ: opcode 1100011, f3 000, rs1=rs2=32'h1234 -> SUB, result 0, resp_zero 1.
//  4. Illegal SLL: opcode 0110011, f3 001 -> resp_illegal 1, result 0, zero 1, alu_control 0010.
//  5. Backpressure: resp_ready low 3 cycles in RESP -> resp_valid and outputs held,
//     req_ready 0; completes on the cycle resp_ready rises.
//  6. Reset in EXEC: assert reset_b=0 one edge -> resp_valid never rises,
//     next cycle req_ready 1, all outputs at reset values.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Request-side sequencer for the datapath ALU: decodes RV32I fields into alu_control,
// drives registered ALU operands and returns the captured result over valid/ready.
module alu_op_sequencer #(
    parameter int unsigned REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic [REG_WIDTH-1:0] rs1_data,
    input  logic [REG_WIDTH-1:0] rs2_data,
    input  logic [REG_WIDTH-1:0] imm,
    output logic [REG_WIDTH-1:0] alu_in1,
    output logic [REG_WIDTH-1:0] alu_in2,
    output logic [3:0]           alu_control,
    input  logic [REG_WIDTH-1:0] alu_result,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [REG_WIDTH-1:0] resp_result,
    output logic                 resp_zero,
    output logic                 resp_illegal
);

    localparam int unsigned OP_W   = 7;
    localparam int unsigned CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] ALU_OR  = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] ALU_XOR = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] ALU_SUB = CTRL_W'(4'b0110);

    localparam logic [OP_W-1:0] OP_R      = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_I      = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_STORE  = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(7'b1100011);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   accept_c;
    logic                   illegal_q;
    logic [CTRL_W-1:0]      dec_ctrl;
    logic [REG_WIDTH-1:0]   dec_in1;
    logic [REG_WIDTH-1:0]   dec_in2;
    logic                   dec_illegal;
    logic [REG_WIDTH-1:0]   exec_result_c;

    // Instruction decode; illegal requests are neutralised to ADD 0 + 0
    always_comb begin
        dec_ctrl    = ALU_ADD;
        dec_in1     = rs1_data;
        dec_in2     = rs2_data;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R, OP_I: begin
                if (opcode == OP_I) begin
                    dec_in2 = imm;
                end
                case (funct3)
                    3'b000:  dec_ctrl = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b100:  dec_ctrl = ALU_XOR;
                    3'b110:  dec_ctrl = ALU_OR;
                    3'b111:  dec_ctrl = ALU_AND;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                dec_in2 = imm;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    dec_ctrl = ALU_SUB;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_ctrl = ALU_ADD;
            dec_in1  = '0;
            dec_in2  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept_c   = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign exec_result_c = illegal_q ? '0 : alu_result;

    // Registered handshake flags, ALU drive and response capture
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            alu_in1      <= '0;
            alu_in2      <= '0;
            alu_control  <= ALU_ADD;
            illegal_q    <= 1'b0;
            resp_result  <= '0;
            resp_zero    <= 1'b0;
            resp_illegal <= 1'b0;
        end else begin
            req_ready  <= (state_next == IDLE);
            resp_valid <= (state_next == RESP);
            if (accept_c) begin
                alu_in1     <= dec_in1;
                alu_in2     <= dec_in2;
                alu_control <= dec_ctrl;
                illegal_q   <= dec_illegal;
            end
            if (state == EXEC) begin
                resp_result  <= exec_result_c;
                resp_zero    <= (exec_result_c == '0);
                resp_illegal <= illegal_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU in the loop.
module tb_alu_op_sequencer;

    localparam int unsigned W  = 32;
    localparam int unsigned NV = 13;

    logic         clk = 1'b0;
    logic         reset_b;
    logic         req_valid;
    logic         req_ready;
    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic         funct7_5;
    logic [W-1:0] rs1_data;
    logic [W-1:0] rs2_data;
    logic [W-1:0] imm;
    logic [W-1:0] alu_in1;
    logic [W-1:0] alu_in2;
    logic [3:0]   alu_control;
    logic [W-1:0] alu_result;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_result;
    logic         resp_zero;
    logic         resp_illegal;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0]   op;
        logic [2:0]   f3;
        logic         f7;
        logic [W-1:0] rs1;
        logic [W-1:0] rs2;
        logic [W-1:0] imm;
        logic [3:0]   ctrl;
        logic [W-1:0] in2;
        logic [W-1:0] res;
        logic         ill;
    } vec_t;

    vec_t vecs [NV];

    alu_op_sequencer #(.REG_WIDTH(W)) dut (
        .clk(clk), .reset_b(reset_b),
        .req_valid(req_valid), .req_ready(req_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
        .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_illegal(resp_illegal)
    );

    always #5 clk = ~clk;

    // Combinational datapath ALU the sequencer drives
    always_comb begin
        case (alu_control)
            4'b0000: alu_result = alu_in1 & alu_in2;
            4'b0001: alu_result = alu_in1 | alu_in2;
            4'b0010: alu_result = alu_in1 + alu_in2;
            4'b0011: alu_result = alu_in1 ^ alu_in2;
            4'b0110: alu_result = alu_in1 - alu_in2;
            default: alu_result = '0;
        endcase
    end

    // Drive a request at a negedge; returns at the EXEC-cycle negedge after acceptance
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] i);
        opcode = op; funct3 = f3; funct7_5 = f7;
        rs1_data = a; rs2_data = b; imm = i;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %0b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %0b exp 0", resp_valid); end
        checks++; if (alu_control !== 4'b0010) begin errors++; $display("FAIL rst_alu_control got %b exp 0010", alu_control); end
        checks++; if (resp_result !== '0 || resp_zero !== 1'b0 || resp_illegal !== 1'b0) begin
            errors++; $display("FAIL rst_resp got %h/%0b/%0b exp 0/0/0", resp_result, resp_zero, resp_illegal);
        end
        checks++; if (alu_in1 !== '0 || alu_in2 !== '0) begin errors++; $display("FAIL rst_alu_in got %h/%h exp 0/0", alu_in1, alu_in2); end
        reset_b = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %0b exp 1", req_ready); end
    endtask

    task automatic test_decode();
        vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd99, 4'b0010, 32'd7, 32'd12, 1'b0};
        vecs[1]  = '{7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd99, 4'b0110, 32'd3, 32'd7, 1'b0};
        vecs[2]  = '{7'b0110011, 3'b000, 1'b1, 32'd0, 32'd1, 32'd99, 4'b0110, 32'd1, 32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{7'b1100011, 3'b000, 1'b0, 32'h1234, 32'h1234, 32'd99, 4'b0110, 32'h1234, 32'd0, 1'b0};
        vecs[4]  = '{7'b0110011, 3'b001, 1'b0, 32'd5, 32'd7, 32'd99, 4'b0010, 32'd0, 32'd0, 1'b1};
        vecs[5]  = '{7'b0110011, 3'b100, 1'b0, 32'hF0F0, 32'h0FF0, 32'd99, 4'b0011, 32'h0FF0, 32'hFF00, 1'b0};
        vecs[6]  = '{7'b0110011, 3'b111, 1'b0, 32'hFF00, 32'h0FF0, 32'd99, 4'b0000, 32'h0FF0, 32'h0F00, 1'b0};
        vecs[7]  = '{7'b0010011, 3'b000, 1'b1, 32'd100, 32'd55, 32'hFFFF_FFFF, 4'b0010, 32'hFFFF_FFFF, 32'd99, 1'b0};
        vecs[8]  = '{7'b0010011, 3'b110, 1'b0, 32'hF0, 32'h3, 32'h0F, 4'b0001, 32'h0F, 32'hFF, 1'b0};
        vecs[9]  = '{7'b0100011, 3'b010, 1'b0, 32'h1000, 32'h77, 32'd4, 4'b0010, 32'd4, 32'h1004, 1'b0};
        vecs[10] = '{7'b0000011, 3'b111, 1'b1, 32'h20, 32'h77, 32'hFFFF_FFFC, 4'b0010, 32'hFFFF_FFFC, 32'h1C, 1'b0};
        vecs[11] = '{7'b1100011, 3'b001, 1'b0, 32'd5, 32'd9, 32'd99, 4'b0110, 32'd9, 32'hFFFF_FFFC, 1'b0};
        vecs[12] = '{7'b0110111, 3'b000, 1'b0, 32'd8, 32'd9, 32'd99, 4'b0010, 32'd0, 32'd0, 1'b1};
        resp_ready = 1'b1;
        for (int i = 0; i < int'(NV); i++) begin
            issue(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            checks++; if (alu_control !== vecs[i].ctrl) begin errors++; $display("FAIL v%0d alu_control got %b exp %b", i, alu_control, vecs[i].ctrl); end
            checks++; if (alu_in1 !== (vecs[i].ill ? '0 : vecs[i].rs1)) begin errors++; $display("FAIL v%0d alu_in1 got %h", i, alu_in1); end
            checks++; if (alu_in2 !== vecs[i].in2) begin errors++; $display("FAIL v%0d alu_in2 got %h exp %h", i, alu_in2, vecs[i].in2); end
            checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
                errors++; $display("FAIL v%0d exec_flags got rdy %0b vld %0b exp 0 0", i, req_ready, resp_valid);
            end
            @(negedge clk);
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL v%0d latency resp_valid got %0b exp 1", i, resp_valid); end
            checks++; if (resp_result !== vecs[i].res) begin errors++; $display("FAIL v%0d resp_result got %h exp %h", i, resp_result, vecs[i].res); end
            checks++; if (resp_zero !== (vecs[i].res == '0)) begin errors++; $display("FAIL v%0d resp_zero got %0b", i, resp_zero); end
            checks++; if (resp_illegal !== vecs[i].ill) begin errors++; $display("FAIL v%0d resp_illegal got %0b exp %0b", i, resp_illegal, vecs[i].ill); end
            @(negedge clk);
            checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++; $display("FAIL v%0d handshake got vld %0b rdy %0b exp 0 1", i, resp_valid, req_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        issue(7'b0110011, 3'b000, 1'b0, 32'h50, 32'h5, 32'd0);
        opcode = 7'b0110011; funct3 = 3'b110; rs1_data = 32'h999; req_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++; if (resp_valid !== 1'b1 || resp_result !== 32'h55 || resp_zero !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got vld %0b res %h zero %0b exp 1 55 0", k, resp_valid, resp_result, resp_zero);
            end
            checks++; if (req_ready !== 1'b0 || alu_in1 !== 32'h50) begin
                errors++; $display("FAIL bp_no_accept%0d got rdy %0b in1 %h exp 0 50", k, req_ready, alu_in1);
            end
            if (k < 2) @(negedge clk);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_result !== 32'h55) begin
            errors++; $display("FAIL bp_release got vld %0b rdy %0b res %h exp 0 1 55", resp_valid, req_ready, resp_result);
        end
    endtask

    task automatic test_back_to_back();
        resp_ready = 1'b1;
        issue(7'b0010011, 3'b100, 1'b0, 32'hAAAA, 32'd0, 32'h00FF);
        opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
        rs1_data = 32'd40; rs2_data = 32'd2; req_valid = 1'b1;
        checks++; if (alu_in1 !== 32'hAAAA || req_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_exec got in1 %h rdy %0b exp aaaa 0", alu_in1, req_ready);
        end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_result !== 32'hAA55 || alu_in1 !== 32'hAAAA) begin
            errors++; $display("FAIL b2b_first got vld %0b res %h in1 %h exp 1 aa55 aaaa", resp_valid, resp_result, alu_in1);
        end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got rdy %0b vld %0b exp 1 0", req_ready, resp_valid);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++; if (alu_in1 !== 32'd40 || alu_control !== 4'b0110) begin
            errors++; $display("FAIL b2b_second_accept got in1 %h ctrl %b exp 28 0110", alu_in1, alu_control);
        end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_result !== 32'd38) begin
            errors++; $display("FAIL b2b_second got vld %0b res %h exp 1 26", resp_valid, resp_result);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_exec();
        resp_ready = 1'b1;
        issue(7'b0110011, 3'b000, 1'b0, 32'd9, 32'd4, 32'd0);
        reset_b = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL rexec_flags got rdy %0b vld %0b exp 1 0", req_ready, resp_valid);
        end
        checks++; if (resp_result !== '0 || resp_zero !== 1'b0 || resp_illegal !== 1'b0) begin
            errors++; $display("FAIL rexec_resp got %h/%0b/%0b exp 0/0/0", resp_result, resp_zero, resp_illegal);
        end
        checks++; if (alu_in1 !== '0 || alu_in2 !== '0 || alu_control !== 4'b0010) begin
            errors++; $display("FAIL rexec_alu got %h/%h/%b exp 0/0/0010", alu_in1, alu_in2, alu_control);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rexec_no_resp%0d got %0b exp 0", k, resp_valid); end
        end
    endtask

    initial begin
        reset_b = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        opcode = '0; funct3 = '0; funct7_5 = 1'b0;
        rs1_data = '0; rs2_data = '0; imm = '0;
        @(negedge clk);
        test_reset();
        test_decode();
        test_backpressure();
        test_back_to_back();
        test_reset_in_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
